posit_encode_pipe: RTL and testbench

Three-stage pipelined posit encoder for 32-bit, es=2 posits. It accepts a serialized value {sgn, scale, fraction, inf, zero}, as produced by the posit field-extraction logic and consumed by the arithmetic units, and packs it back into a posit word. Packing uses round-to-nearest-even and saturates at maxpos/minpos. It sits at the output of every arithmetic datapath, between the serialized-domain result and the posit-domain result register/FIFO.

---
 rtl/posit_defines.sv | 34 +++
 rtl/shift_right.sv | 31 +++
 rtl/posit_encode_pipe.sv | 129 ++++++++++++
 tb/tb_posit_encode_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_defines.sv
// Shared posit constants and the serialized-value layout used by the
// field-extraction logic, the arithmetic units and the encoder.
package posit_defines;

   localparam int NBITS = 32;
   localparam int ES    = 2;
   localparam int POSIT_SERIALIZED_WIDTH_ES2 = 38;

   localparam int SCALE_W = 8;
   localparam int FRAC_W  = 27;
   localparam int MAG_W   = NBITS - 1;

   typedef struct packed {
      logic                      sgn;
      logic signed [SCALE_W-1:0] scale;
      logic [FRAC_W-1:0]         fraction;
      logic                      inf;
      logic                      zero;
   } value;

   localparam logic [MAG_W-1:0] POSIT_MAXPOS    = 31'h7FFFFFFF;
   localparam logic [MAG_W-1:0] POSIT_MINPOS    = 31'h00000001;
   localparam logic [NBITS-1:0] POSIT_NAR       = 32'h80000000;
   localparam int               POSIT_MAX_SCALE = 120;

   localparam int SHIFT_N = 64;
   localparam int SHIFT_S = 6;

   // Regime alignment distance: k for k >= 0, -k-1 (= ~k) for k < 0.
   function automatic logic [SHIFT_S-1:0] regime_shift(input logic [SHIFT_S-1:0] k);
      return k[SHIFT_S-1] ? ~k : k;
   endfunction

endpackage

// File: rtl/shift_right.sv
// Logarithmic arithmetic right shifter; the fill bit is the input MSB,
// which lets one shifter emit either a run of ones or a run of zeros.
module shift_right #(
   parameter int N = 64,
   parameter int S = 6
) (
   input  logic [N-1:0] data_i,
   input  logic [S-1:0] shamt_i,
   output logic [N-1:0] data_o
);

   genvar gi;
   generate
      for (gi = 0; gi < S; gi++) begin : g_stage
         localparam int AMT = 1 << gi;
         logic [N-1:0] prev_w;
         logic [N-1:0] cur_w;

         if (gi == 0) begin : g_first
            assign prev_w = data_i;
         end else begin : g_rest
            assign prev_w = g_stage[gi-1].cur_w;
         end

         assign cur_w = shamt_i[gi] ? {{AMT{prev_w[N-1]}}, prev_w[N-1:AMT]} : prev_w;
      end
   endgenerate

   assign data_o = g_stage[S-1].cur_w;

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit<32,2> encoder: serialized {sgn, scale, fraction, inf, zero}
// in, round-to-nearest-even posit word out, with a single global stall.
module posit_encode_pipe
   import posit_defines::*;
(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] in_data,
   input  logic                                  in_sticky,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NBITS-1:0]                      out_data
);

   localparam int PAD_W = SHIFT_N - 2 - ES - FRAC_W;
   localparam logic signed [SCALE_W-1:0] SCALE_HI = SCALE_W'(POSIT_MAX_SCALE);
   localparam logic signed [SCALE_W-1:0] SCALE_LO = SCALE_W'(-POSIT_MAX_SCALE);

   logic advance;

   // Stage 1 state
   logic               s1_valid_q;
   logic               s1_sgn_q, s1_inf_q, s1_zero_q, s1_sticky_q;
   logic               s1_sat_max_q, s1_sat_min_q;
   logic [SHIFT_N-1:0] s1_shift_q;
   // Stage 2 state
   logic               s2_valid_q;
   logic               s2_sgn_q, s2_inf_q, s2_zero_q;
   logic [MAG_W-1:0]   s2_mag_q;
   // Stage 3 state (output register)
   logic               s3_valid_q;
   logic [NBITS-1:0]   s3_data_q;

   assign advance   = !s3_valid_q || out_ready;
   assign in_ready  = advance;
   assign out_valid = s3_valid_q;
   assign out_data  = s3_data_q;

   // ---------------- Stage 1: decode, saturation flags, regime shift
   value                in_v;
   logic [SHIFT_S-1:0]  k_w;
   logic                s1_sat_max_d, s1_sat_min_d;
   logic [SHIFT_N-1:0]  seed_w;
   logic [SHIFT_N-1:0]  s1_shift_d;

   assign in_v         = value'(in_data);
   assign k_w          = in_v.scale[SCALE_W-1:ES];
   assign s1_sat_max_d = $signed(in_v.scale) > SCALE_HI;
   assign s1_sat_min_d = $signed(in_v.scale) < SCALE_LO;

   // Leading pair is {regime bit, terminator}; the arithmetic shift
   // replicates the regime bit to the required run length.
   assign seed_w = {~k_w[SHIFT_S-1], k_w[SHIFT_S-1], in_v.scale[ES-1:0],
                    in_v.fraction, {PAD_W{1'b0}}};

   shift_right #(
      .N (SHIFT_N),
      .S (SHIFT_S)
   ) u_shift_right (
      .data_i  (seed_w),
      .shamt_i (regime_shift(k_w)),
      .data_o  (s1_shift_d)
   );

   // ---------------- Stage 2: guard/sticky extraction, RNE, saturation
   logic [MAG_W-1:0] mag_w;
   logic             guard_w, sticky_w, round_up_w;
   logic [MAG_W-1:0] s2_mag_d;

   assign mag_w      = s1_shift_q[SHIFT_N-1 -: MAG_W];
   assign guard_w    = s1_shift_q[SHIFT_N-1-MAG_W];
   assign sticky_w   = (|s1_shift_q[SHIFT_N-2-MAG_W:0]) | s1_sticky_q;
   assign round_up_w = guard_w & (sticky_w | mag_w[0]) & (mag_w != POSIT_MAXPOS);

   always_comb begin
      s2_mag_d = mag_w + MAG_W'(round_up_w);
      if (s1_sat_max_q) begin
         s2_mag_d = POSIT_MAXPOS;
      end else if (s1_sat_min_q) begin
         s2_mag_d = POSIT_MINPOS;
      end
   end

   // ---------------- Stage 3: sign and specials
   logic [NBITS-1:0] mag_ext_w;
   logic [NBITS-1:0] s3_data_d;

   assign mag_ext_w = {1'b0, s2_mag_q};

   always_comb begin
      s3_data_d = s2_sgn_q ? -mag_ext_w : mag_ext_w;
      if (s2_zero_q) begin
         s3_data_d = '0;
      end else if (s2_inf_q) begin
         s3_data_d = POSIT_NAR;
      end
   end

   // Whole pipe moves as one; a stall freezes data and valid bits alike.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s3_data_q  <= '0;
      end else if (advance) begin
         s1_valid_q   <= in_valid;
         s1_sgn_q     <= in_v.sgn;
         s1_inf_q     <= in_v.inf;
         s1_zero_q    <= in_v.zero;
         s1_sticky_q  <= in_sticky;
         s1_sat_max_q <= s1_sat_max_d;
         s1_sat_min_q <= s1_sat_min_d;
         s1_shift_q   <= s1_shift_d;

         s2_valid_q   <= s1_valid_q;
         s2_sgn_q     <= s1_sgn_q;
         s2_inf_q     <= s1_inf_q;
         s2_zero_q    <= s1_zero_q;
         s2_mag_q     <= s2_mag_d;

         s3_valid_q   <= s2_valid_q;
         s3_data_q    <= s3_data_d;
      end
   end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Scoreboard bench for posit_encode_pipe: directed encodings, a backpressured
// random stream, and a mid-stream reset.
module tb_posit_encode_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [37:0] in_data = '0;
   logic        in_sticky = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cycle = 0;
   logic [31:0] exp_q[$];
   int          acc_q[$];
   logic [31:0] exp_in = '0;
   logic        acc_flag = 1'b0;
   logic        strict_lat = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_data = '0;
   logic        stream_done = 1'b0;

   posit_encode_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sticky (in_sticky),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s got=%h required=%h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Bit-serial reference: lay regime, exponent and fraction down one bit at a time.
   function automatic logic [31:0] ref_posit(input logic sgn, input int scale, input logic [26:0] frac,
                                             input logic sticky, input logic inf, input logic zero);
      logic [127:0] v;
      logic [30:0]  m;
      logic [1:0]   ev;
      logic         g, s;
      logic [31:0]  r;
      int           pos, k;
      if (zero) return 32'h0;
      if (inf) return 32'h80000000;
      if (scale > 120) begin
         m = 31'h7FFFFFFF;
      end else if (scale < -120) begin
         m = 31'h1;
      end else begin
         k  = (scale >= 0) ? scale / 4 : -((3 - scale) / 4);
         ev = 2'(scale - 4 * k);
         v  = '0;
         pos = 127;
         if (k >= 0) begin
            for (int i = 0; i <= k; i++) begin
               v[pos] = 1'b1;
               pos = pos - 1;
            end
            pos = pos - 1;
         end else begin
            pos = 127 + k;
            v[pos] = 1'b1;
            pos = pos - 1;
         end
         v[pos] = ev[1]; pos = pos - 1;
         v[pos] = ev[0]; pos = pos - 1;
         for (int i = 26; i >= 0; i--) begin
            v[pos] = frac[i];
            pos = pos - 1;
         end
         m = v[127:97];
         g = v[96];
         s = (|v[95:0]) | sticky;
         if (g && (s || m[0]) && (m != 31'h7FFFFFFF)) m = m + 31'd1;
      end
      r = {1'b0, m};
      if (sgn) r = -r;
      return r;
   endfunction

   // Monitor: sample mid-cycle, retire outputs, then record acceptances.
   always @(negedge clk) begin
      cycle = cycle + 1;
      if (reset) begin
         exp_q.delete();
         acc_q.delete();
         stall_prev = 1'b0;
      end else begin
         check_eq("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (stall_prev) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               logic [31:0] e;
               int          a;
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check_eq("out_data", out_data, e);
               if (strict_lat) check_eq("latency", 32'(cycle - a), 32'd3);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_in);
            acc_q.push_back(cycle);
            acc_flag = 1'b1;
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic send(input logic [37:0] d, input logic st, input logic [31:0] exp);
      bit done;
      done      = 1'b0;
      in_data   = d;
      in_sticky = st;
      exp_in    = exp;
      in_valid  = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(posedge clk);
         #1;
         if (acc_flag) begin
            acc_flag = 1'b0;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      check_eq("accepted", 32'(done), 32'd1);
   endtask

   task automatic send_fields(input logic sgn, input int scale, input logic [26:0] frac,
                              input logic st, input logic inf, input logic zero, input logic [31:0] exp);
      send({sgn, 8'(scale), frac, inf, zero}, st, exp);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      check_eq("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", out_data, 32'h0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed encodings, back-to-back with the sink always ready.
      strict_lat = 1'b1;
      send_fields(0,    0, 27'h0,       0, 0, 0, 32'h40000000);
      send_fields(1,    0, 27'h0,       0, 0, 0, 32'hC0000000);
      send_fields(0,    4, 27'h0,       0, 0, 0, 32'h60000000);
      send_fields(0,   -1, 27'h0,       0, 0, 0, 32'h38000000);
      send_fields(0,   -8, 27'h0,       0, 0, 0, 32'h10000000);
      send_fields(0,    8, 27'h3,       0, 0, 0, 32'h70000001);
      send_fields(0,    8, 27'h2,       0, 0, 0, 32'h70000000);
      send_fields(0,    8, 27'h2,       1, 0, 0, 32'h70000001);
      send_fields(0,    8, 27'h6,       0, 0, 0, 32'h70000002);
      send_fields(0,    8, 27'h7FFFFFF, 0, 0, 0, 32'h72000000);
      send_fields(1,    8, 27'h7FFFFFF, 0, 0, 0, 32'h8E000000);
      send_fields(0,  127, 27'h0,       0, 0, 0, 32'h7FFFFFFF);
      send_fields(1,  127, 27'h0,       0, 0, 0, 32'h80000001);
      send_fields(0,  120, 27'h7FFFFFF, 0, 0, 0, 32'h7FFFFFFF);
      send_fields(0, -120, 27'h0,       0, 0, 0, 32'h00000001);
      send_fields(0, -121, 27'h0,       0, 0, 0, 32'h00000001);
      send_fields(0, -128, 27'h0,       0, 0, 0, 32'h00000001);
      send_fields(0,    5, 27'h1234,    0, 0, 1, 32'h00000000);
      send_fields(1,    5, 27'h1234,    0, 1, 0, 32'h80000000);
      send_fields(0,    5, 27'h1234,    0, 1, 1, 32'h00000000);
      wait_drain();
      strict_lat = 1'b0;

      // Random stream against a toggling sink.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic              sg, st, nf, zr;
               logic signed [7:0] sc;
               logic [26:0]       fr;
               sg = 1'($urandom);
               st = 1'($urandom);
               sc = 8'($urandom);
               fr = 27'($urandom);
               nf = ($urandom_range(0, 15) == 0);
               zr = ($urandom_range(0, 15) == 0);
               send({sg, sc, fr, nf, zr}, st, ref_posit(sg, int'(sc), fr, st, nf, zr));
               if ($urandom_range(0, 2) == 0) @(posedge clk);
               #0;
            end
            stream_done = 1'b1;
         end
         begin
            for (int t = 0; t < 3000 && !stream_done; t++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();

      // Reset with three items in flight and the sink stalled.
      out_ready = 1'b0;
      send_fields(0, 12, 27'h55555, 0, 0, 0, ref_posit(0, 12, 27'h55555, 0, 0, 0));
      send_fields(1, -9, 27'h0ABCD, 1, 0, 0, ref_posit(1, -9, 27'h0ABCD, 1, 0, 0));
      send_fields(0, 33, 27'h7000F, 0, 0, 0, ref_posit(0, 33, 27'h7000F, 0, 0, 0));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_out_data", out_data, 32'h0);
      check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      strict_lat = 1'b1;
      send_fields(0, 2, 27'h4000000, 0, 0, 0, ref_posit(0, 2, 27'h4000000, 0, 0, 0));
      wait_drain();
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
